// File: rtl/apu_issue_ctrl.sv
// Core-side APU initiator: one outstanding vector instruction, req/gnt toward the vector unit,
// result capture with optional scalar writeback, and a watchdog that aborts lost results.
module apu_issue_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter int unsigned CNT_W          = 7
) (
    input  logic             clk,
    input  logic             reset,

    input  logic             issue_valid,
    output logic             issue_ready,
    input  logic [31:0]      issue_instr,
    input  logic [31:0]      issue_rs1,
    input  logic [31:0]      issue_rs2,
    input  logic [5:0]       issue_op,
    input  logic [14:0]      issue_flags,

    output logic             apu_req,
    input  logic             apu_gnt,
    output logic [2:0][31:0] apu_operands,
    output logic [5:0]       apu_op,
    output logic [14:0]      apu_flags_o,
    input  logic             apu_rvalid,
    input  logic [31:0]      apu_result,

    output logic             wb_valid,
    output logic             wb_we,
    output logic [4:0]       wb_rd,
    output logic [31:0]      wb_data,

    output logic             busy,
    output logic             timeout_err
);

    localparam logic [6:0] OpcodeOpV      = 7'b1010111;
    localparam logic [2:0] Funct3OpCfg    = 3'b111;
    localparam logic [2:0] Funct3OpMvv    = 3'b010;
    localparam logic [5:0] Funct6Wxunary0 = 6'b010000;
    localparam bit         WatchdogEn     = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] CntLast  =
        CNT_W'(TIMEOUT_CYCLES == 0 ? 0 : TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StReq, StWaitRes} state_e;

    state_e           state_q, state_d;
    logic [31:0]      rs1_q, rs2_q, instr_q;
    logic [5:0]       op_q;
    logic [14:0]      flags_q;
    logic             we_pending_q;
    logic [CNT_W-1:0] cnt_q;
    logic             wb_valid_q, wb_we_q;
    logic [4:0]       wb_rd_q;
    logic [31:0]      wb_data_q;

    logic accept, granted, res_hit, wdog_fire, we_dec;

    assign accept    = issue_valid & (state_q == StIdle);
    assign granted   = apu_gnt & (state_q == StReq);
    assign res_hit   = apu_rvalid & (state_q == StWaitRes);
    // Same-cycle rvalid takes priority over the abort.
    assign wdog_fire = WatchdogEn & (state_q == StWaitRes) & ~apu_rvalid & (cnt_q == CntLast);

    // Scalar writeback only for vsetvl{i} and vmv.x.s with a non-zero rd.
    always_comb begin
        we_dec = (issue_instr[6:0] == OpcodeOpV) && (issue_instr[11:7] != 5'd0) &&
                 ((issue_instr[14:12] == Funct3OpCfg) ||
                  ((issue_instr[14:12] == Funct3OpMvv) && (issue_instr[31:26] == Funct6Wxunary0)));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (issue_valid) state_d = StReq;
            StReq:     if (apu_gnt) state_d = StWaitRes;
            StWaitRes: if (apu_rvalid || wdog_fire) state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    always_comb begin
        issue_ready = 1'b0;
        apu_req     = 1'b0;
        busy        = 1'b1;
        timeout_err = 1'b0;
        unique case (state_q)
            StIdle: begin
                issue_ready = 1'b1;
                busy        = 1'b0;
            end
            StReq:     apu_req = 1'b1;
            StWaitRes: timeout_err = wdog_fire;
            default: begin
                issue_ready = 1'b0;
                busy        = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rs1_q        <= '0;
            rs2_q        <= '0;
            instr_q      <= '0;
            op_q         <= '0;
            flags_q      <= '0;
            we_pending_q <= 1'b0;
            cnt_q        <= '0;
        end else begin
            if (accept) begin
                rs1_q        <= issue_rs1;
                rs2_q        <= issue_rs2;
                instr_q      <= issue_instr;
                op_q         <= issue_op;
                flags_q      <= issue_flags;
                we_pending_q <= we_dec;
            end
            if (granted) begin
                cnt_q <= '0;
            end else if (state_q == StWaitRes) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wb_valid_q <= 1'b0;
            wb_we_q    <= 1'b0;
            wb_rd_q    <= '0;
            wb_data_q  <= '0;
        end else begin
            wb_valid_q <= res_hit;
            wb_we_q    <= res_hit & we_pending_q;
            if (res_hit) begin
                wb_rd_q   <= instr_q[11:7];
                wb_data_q <= apu_result;
            end
        end
    end

    assign apu_operands[0] = rs1_q;
    assign apu_operands[1] = rs2_q;
    assign apu_operands[2] = instr_q;
    assign apu_op          = op_q;
    assign apu_flags_o     = flags_q;
    assign wb_valid        = wb_valid_q;
    assign wb_we           = wb_we_q;
    assign wb_rd           = wb_rd_q;
    assign wb_data         = wb_data_q;

endmodule

// File: tb/tb_apu_issue_ctrl.sv
// Bench for apu_issue_ctrl: directed vector table plus randomized transactions checked against
// a transaction-level model of accept / grant / result-or-timeout timing.
module tb_apu_issue_ctrl;

    localparam int unsigned TO = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic             issue_valid, issue_ready;
    logic [31:0]      issue_instr, issue_rs1, issue_rs2;
    logic [5:0]       issue_op;
    logic [14:0]      issue_flags;
    logic             apu_req, apu_gnt;
    logic [2:0][31:0] apu_operands;
    logic [5:0]       apu_op;
    logic [14:0]      apu_flags_o;
    logic             apu_rvalid;
    logic [31:0]      apu_result;
    logic             wb_valid, wb_we;
    logic [4:0]       wb_rd;
    logic [31:0]      wb_data;
    logic             busy, timeout_err;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [5:0]  op;
        logic [14:0] flags;
        logic [31:0] result;
        int          gnt_dly;
        int          rsp_dly;
        bit          exp_we;
    } vec_t;

    apu_issue_ctrl #(
        .TIMEOUT_CYCLES(TO),
        .CNT_W         (7)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .issue_valid (issue_valid),
        .issue_ready (issue_ready),
        .issue_instr (issue_instr),
        .issue_rs1   (issue_rs1),
        .issue_rs2   (issue_rs2),
        .issue_op    (issue_op),
        .issue_flags (issue_flags),
        .apu_req     (apu_req),
        .apu_gnt     (apu_gnt),
        .apu_operands(apu_operands),
        .apu_op      (apu_op),
        .apu_flags_o (apu_flags_o),
        .apu_rvalid  (apu_rvalid),
        .apu_result  (apu_result),
        .wb_valid    (wb_valid),
        .wb_we       (wb_we),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL global_time_limit: got no finish, required finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h required %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            next_cycle();
            issue_valid = 1'b0;
            apu_gnt     = 1'b0;
            apu_rvalid  = 1'b0;
            #1;
            chk("idle_ready", issue_ready, 1'b1);
        end
    endtask

    // Writeback rule stated on instruction fields.
    function automatic bit model_we(input logic [31:0] i);
        bit is_opv, cfg, mvxs;
        is_opv = (i[6:0] == 7'h57);
        cfg    = (i[14:12] == 3'd7);
        mvxs   = (i[14:12] == 3'd2) && (i[31:26] == 6'd16);
        return is_opv && (i[11:7] != 0) && (cfg || mvxs);
    endfunction

    function automatic vec_t mk(input logic [31:0] instr, input logic [31:0] result,
                                input int g, input int r, input bit we);
        vec_t v;
        v.instr   = instr;
        v.rs1     = $urandom;
        v.rs2     = $urandom;
        v.op      = 6'($urandom);
        v.flags   = 15'($urandom);
        v.result  = result;
        v.gnt_dly = g;
        v.rsp_dly = r;
        v.exp_we  = we;
        return v;
    endfunction

    // Starts in an idle cycle (already sampled), ends in the completion cycle without advancing.
    task automatic run_txn(input vec_t v);
        bool_t_dummy: begin end
        issue_valid = 1'b1;
        issue_instr = v.instr;
        issue_rs1   = v.rs1;
        issue_rs2   = v.rs2;
        issue_op    = v.op;
        issue_flags = v.flags;
        apu_gnt     = 1'($urandom);
        apu_rvalid  = 1'($urandom);
        #1;
        chk("accept_ready", issue_ready, 1'b1);
        chk("accept_req", apu_req, 1'b0);
        for (int k = 0; k <= v.gnt_dly; k++) begin
            next_cycle();
            issue_valid = 1'($urandom);
            issue_instr = $urandom;
            issue_rs1   = $urandom;
            issue_rs2   = $urandom;
            issue_op    = 6'($urandom);
            issue_flags = 15'($urandom);
            apu_gnt     = (k == v.gnt_dly);
            apu_rvalid  = 1'($urandom);
            #1;
            chk("req_high", apu_req, 1'b1);
            chk("req_ready_low", issue_ready, 1'b0);
            chk("req_busy", busy, 1'b1);
            chk("req_rs1", apu_operands[0], v.rs1);
            chk("req_rs2", apu_operands[1], v.rs2);
            chk("req_instr", apu_operands[2], v.instr);
            chk("req_op", apu_op, v.op);
            chk("req_flags", apu_flags_o, v.flags);
            chk("req_no_wb", wb_valid, 1'b0);
        end
        for (int k = 0; k < int'(TO) && k <= v.rsp_dly; k++) begin
            next_cycle();
            issue_valid = 1'($urandom);
            apu_gnt     = 1'($urandom);
            apu_rvalid  = (k == v.rsp_dly);
            apu_result  = (k == v.rsp_dly) ? v.result : $urandom;
            #1;
            chk("wait_req_low", apu_req, 1'b0);
            chk("wait_ready_low", issue_ready, 1'b0);
            chk("wait_busy", busy, 1'b1);
            chk("wait_no_wb", wb_valid, 1'b0);
            chk("wait_timeout", timeout_err, (v.rsp_dly >= int'(TO)) && (k == int'(TO) - 1));
        end
        next_cycle();
        issue_valid = 1'b0;
        apu_gnt     = 1'b0;
        apu_rvalid  = 1'b0;
        #1;
        chk("done_ready", issue_ready, 1'b1);
        chk("done_busy", busy, 1'b0);
        chk("done_timeout_low", timeout_err, 1'b0);
        chk("done_wb_valid", wb_valid, v.rsp_dly < int'(TO));
        if (v.rsp_dly < int'(TO)) begin
            chk("done_wb_we", wb_we, v.exp_we);
            chk("done_wb_rd", wb_rd, v.instr[11:7]);
            chk("done_wb_data", wb_data, v.result);
        end else begin
            chk("done_wb_we_low", wb_we, 1'b0);
        end
    endtask

    initial begin
        vec_t        tbl[10];
        vec_t        v;
        logic [31:0] vadd, vsetvli_x5, vmvxs_x0, vmvxs_x7, vsetvl_x9, vsetvli_x0, vle, vredsum;

        vadd       = 32'h022080D7;
        vsetvli_x5 = {1'b0, 11'h0D0, 5'd10, 3'b111, 5'd5, 7'h57};
        vmvxs_x0   = {6'b010000, 1'b1, 5'd3, 5'd0, 3'b010, 5'd0, 7'h57};
        vmvxs_x7   = {6'b010000, 1'b1, 5'd4, 5'd0, 3'b010, 5'd7, 7'h57};
        vsetvl_x9  = {7'b1000000, 5'd2, 5'd1, 3'b111, 5'd9, 7'h57};
        vsetvli_x0 = {1'b0, 11'h010, 5'd6, 3'b111, 5'd0, 7'h57};
        vle        = {12'h000, 5'd1, 3'b111, 5'd5, 7'h07};
        vredsum    = {6'b000000, 1'b1, 5'd2, 5'd1, 3'b010, 5'd3, 7'h57};

        tbl[0] = mk(vadd,       32'h1111_0001, 0, 0,  1'b0);
        tbl[1] = mk(vadd,       32'h1111_0002, 0, 1,  1'b0);
        tbl[2] = mk(vsetvli_x5, 32'd4,         0, 0,  1'b1);
        tbl[3] = mk(vmvxs_x0,   32'hDEAD_BEEF, 1, 2,  1'b0);
        tbl[4] = mk(vmvxs_x7,   32'hCAFE_0007, 5, 3,  1'b1);
        tbl[5] = mk(vsetvl_x9,  32'h0000_0009, 0, 9,  1'b1);
        tbl[6] = mk(vsetvl_x9,  32'h0000_0010, 2, 7,  1'b1);
        tbl[7] = mk(vle,        32'h5555_AAAA, 0, 0,  1'b0);
        tbl[8] = mk(vredsum,    32'h0BAD_F00D, 0, 4,  1'b0);
        tbl[9] = mk(vsetvli_x0, 32'd8,         3, 0,  1'b0);

        reset       = 1'b1;
        issue_valid = 1'b0;
        issue_instr = '0;
        issue_rs1   = '0;
        issue_rs2   = '0;
        issue_op    = '0;
        issue_flags = '0;
        apu_gnt     = 1'b0;
        apu_rvalid  = 1'b0;
        apu_result  = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req", apu_req, 1'b0);
        chk("rst_wb_valid", wb_valid, 1'b0);
        chk("rst_wb_we", wb_we, 1'b0);
        chk("rst_wb_rd", wb_rd, 5'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_timeout", timeout_err, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_op", apu_op, 6'd0);
        chk("rst_flags", apu_flags_o, 15'd0);
        chk("rst_operand2", apu_operands[2], 32'd0);
        reset = 1'b0;
        idle(1);

        // Even entries chain directly into the next issue in the completion cycle.
        for (int i = 0; i < 10; i++) begin
            run_txn(tbl[i]);
            if (i % 2 == 1) idle(1);
        end

        // Reset during WAIT_RES, then a stray rvalid for the aborted request.
        idle(1);
        issue_valid = 1'b1;
        issue_instr = vsetvli_x5;
        issue_op    = 6'h2A;
        next_cycle();
        issue_valid = 1'b0;
        apu_gnt     = 1'b1;
        next_cycle();
        apu_gnt = 1'b0;
        next_cycle();
        next_cycle();
        #1;
        chk("pre_rst_busy", busy, 1'b1);
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        #1;
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_op_cleared", apu_op, 6'd0);
        chk("midrst_timeout", timeout_err, 1'b0);
        apu_rvalid = 1'b1;
        apu_result = 32'h7777_7777;
        #1;
        chk("stray_timeout", timeout_err, 1'b0);
        next_cycle();
        apu_rvalid = 1'b0;
        #1;
        chk("stray_no_wb", wb_valid, 1'b0);
        chk("stray_ready", issue_ready, 1'b1);
        chk("stray_busy", busy, 1'b0);
        chk("stray_no_timeout", timeout_err, 1'b0);
        run_txn(mk(vsetvli_x5, 32'd12, 1, 2, 1'b1));
        idle(1);

        // Randomized transactions.
        for (int i = 0; i < 40; i++) begin
            logic [31:0] ins;
            ins        = $urandom;
            ins[6:0]   = ($urandom_range(0, 4) == 0) ? 7'h07 : 7'h57;
            ins[14:12] = ($urandom_range(0, 1) == 0) ? 3'($urandom) :
                         (($urandom_range(0, 1) == 0) ? 3'b111 : 3'b010);
            if ($urandom_range(0, 1) == 0) ins[31:26] = 6'b010000;
            if ($urandom_range(0, 4) == 0) ins[11:7] = 5'd0;
            v = mk(ins, $urandom, $urandom_range(0, 4), $urandom_range(0, 10), model_we(ins));
            run_txn(v);
            if ($urandom_range(0, 1) == 0) idle($urandom_range(1, 2));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
